// File: rtl/alu.sv
// 8-bit signed ALU with combinational result/flags, controller next-state
// decode and a registered accumulator of the last non-overflowing result.
module alu (
    input  logic              clk,
    input  logic              rst,
    input  logic        [2:0] funct,
    input  logic signed [7:0] A,
    input  logic signed [7:0] B,
    input  logic        [1:0] currentState,
    output logic        [1:0] nextState,
    output logic        [7:0] accumulator,
    output logic signed [7:0] out,
    output logic              carry,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ARITH = 2'd1,
        ST_LOGIC = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    logic [8:0]  w_sum;
    logic [15:0] w_shl;
    logic [15:0] w_shr;
    logic [7:0]  w_out;
    logic        w_carry;
    logic        w_ovf;
    logic [7:0]  r_acc;

    // Raw operation result and flags, before the ERROR-state override.
    // Shifts run in a 16-bit window so the last bit shifted out lands in a
    // fixed position (0 when the amount is zero).
    always_comb begin
        w_sum   = 9'd0;
        w_shl   = 16'd0;
        w_shr   = 16'd0;
        w_out   = 8'd0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (funct)
            3'd0: begin
                w_sum   = {1'b0, A} + {1'b0, B};
                w_out   = w_sum[7:0];
                w_carry = w_sum[8];
                w_ovf   = (A[7] == B[7]) && (w_sum[7] != A[7]);
            end
            3'd1: begin
                w_sum   = {1'b0, A} + {1'b0, ~B} + 9'd1;
                w_out   = w_sum[7:0];
                w_carry = w_sum[8];
                w_ovf   = (A[7] != B[7]) && (w_sum[7] != A[7]);
            end
            3'd2: begin
                w_shl   = {8'd0, A} << B[2:0];
                w_out   = w_shl[7:0];
                w_carry = w_shl[8];
            end
            3'd3: begin
                w_shr   = {A, 8'd0} >> B[2:0];
                w_out   = w_shr[15:8];
                w_carry = w_shr[7];
            end
            3'd4: w_out = A & B;
            3'd5: w_out = A | B;
            3'd6: w_out = A ^ B;
            3'd7: w_out = ~A;
            default: w_out = 8'd0;
        endcase
    end

    // ERROR state blanks the datapath and steers the controller back to READY.
    always_comb begin
        out       = 8'd0;
        carry     = 1'b0;
        overflow  = 1'b0;
        nextState = ST_READY;
        if (currentState == ST_ERROR) begin
            out       = 8'd0;
            carry     = 1'b0;
            overflow  = 1'b0;
            nextState = ST_READY;
        end else begin
            out      = w_out;
            carry    = w_carry;
            overflow = w_ovf;
            if (w_ovf) begin
                nextState = ST_ERROR;
            end else if (funct[2]) begin
                nextState = ST_LOGIC;
            end else begin
                nextState = ST_ARITH;
            end
        end
    end

    // Commit only valid results; reset wins over a pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'd0;
        end else if ((currentState != ST_ERROR) && !overflow) begin
            r_acc <= out;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign accumulator = r_acc;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps followed by random
// operations, all compared against an integer-arithmetic reference model.
module tb_alu;

    logic              clk;
    logic              rst;
    logic        [2:0] funct;
    logic signed [7:0] A;
    logic signed [7:0] B;
    logic        [1:0] currentState;
    logic        [1:0] nextState;
    logic        [7:0] accumulator;
    logic signed [7:0] out;
    logic              carry;
    logic              overflow;

    int checks   = 0;
    int failures = 0;
    int exp_acc  = 0;

    alu dut (
        .clk          (clk),
        .rst          (rst),
        .funct        (funct),
        .A            (A),
        .B            (B),
        .currentState (currentState),
        .nextState    (nextState),
        .accumulator  (accumulator),
        .out          (out),
        .carry        (carry),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model in plain integer arithmetic on unsigned/signed views.
    task automatic model(input int f, input int a, input int b, input int st,
                         output int o, output int c, output int v, output int ns);
        int sa, sb, n;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        n  = b % 8;
        c  = 0;
        v  = 0;
        case (f)
            0: begin
                o = (a + b) % 256;
                c = (a + b > 255) ? 1 : 0;
                v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
            end
            1: begin
                o = (a - b + 256) % 256;
                c = (a >= b) ? 1 : 0;
                v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
            end
            2: begin
                o = (a * (1 << n)) % 256;
                c = (n == 0) ? 0 : ((a >> (8 - n)) & 1);
            end
            3: begin
                o = a >> n;
                c = (n == 0) ? 0 : ((a >> (n - 1)) & 1);
            end
            4: o = a & b;
            5: o = a | b;
            6: o = a ^ b;
            default: o = 255 - a;
        endcase
        if (st == 3) begin
            o = 0; c = 0; v = 0; ns = 0;
        end else begin
            ns = (v != 0) ? 3 : ((f < 4) ? 1 : 2);
        end
    endtask

    task automatic step(input string tag, input int f, input int a, input int b,
                        input int st, input logic r);
        int o, c, v, ns;
        logic [7:0] eo;
        logic [7:0] ea;
        funct        = 3'(f);
        A            = 8'(a);
        B            = 8'(b);
        currentState = 2'(st);
        rst          = r;
        #2;
        model(f, a, b, st, o, c, v, ns);
        eo = 8'(o);
        chk({tag, " out"}, out, eo);
        chk({tag, " carry"}, {7'd0, carry}, 8'(c));
        chk({tag, " ovf"}, {7'd0, overflow}, 8'(v));
        chk({tag, " next"}, {6'd0, nextState}, 8'(ns));
        if (r) begin
            exp_acc = 0;
        end else if (st != 3 && v == 0) begin
            exp_acc = o;
        end
        @(posedge clk);
        #1;
        ea = 8'(exp_acc);
        chk({tag, " acc"}, accumulator, ea);
    endtask

    initial begin
        funct = 3'd0; A = 8'sd0; B = 8'sd0; currentState = 2'd0; rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset acc", accumulator, 8'h00);

        // Test-plan directed steps, with literal expectations where the plan gives them.
        step("add", 0, 24, 6, 0, 1'b0);
        chk("tp add out", out, 8'd30);
        chk("tp add acc", accumulator, 8'd30);
        step("sub", 1, 24, 6, 0, 1'b0);
        chk("tp sub out", out, 8'd18);
        chk("tp sub carry", {7'd0, carry}, 8'd1);
        step("shl", 2, 24, 6, 0, 1'b0);
        step("shr", 3, 24, 6, 0, 1'b0);
        step("and", 4, 24, 6, 0, 1'b0);
        step("or", 5, 24, 6, 0, 1'b0);
        chk("tp or out", out, 8'd30);
        step("xor", 6, 24, 6, 0, 1'b0);
        step("not", 7, 24, 6, 0, 1'b0);
        chk("tp not out", out, 8'hE7);
        chk("tp not next", {6'd0, nextState}, 8'd2);
        step("add ovf", 0, 100, 100, 1, 1'b0);
        chk("tp ovf out", out, 8'hC8);
        chk("tp ovf acc held", accumulator, 8'hE7);
        step("sub ovf", 1, 128, 1, 2, 1'b0);
        chk("tp sub ovf out", out, 8'd127);
        step("err", 0, 1, 1, 3, 1'b0);
        chk("tp err acc", accumulator, 8'd127 ^ 8'd127 ^ 8'hE7);
        step("shl edge", 2, 8'h81, 1, 0, 1'b0);
        chk("tp shl out", out, 8'h02);
        step("shr edge", 3, 8'h01, 1, 0, 1'b0);
        chk("tp shr carry", {7'd0, carry}, 8'd1);
        step("shl b0", 2, 8'h5A, 0, 0, 1'b0);
        step("shr b0", 3, 8'hA5, 0, 0, 1'b0);
        step("shl b9", 2, 8'h81, 9, 0, 1'b0);
        chk("tp shl b9 out", out, 8'h02);
        step("shr b7", 3, 8'h80, 7, 0, 1'b0);

        // Reset with a valid ADD pending, then normal loading resumes.
        step("pre rst", 0, 24, 6, 0, 1'b0);
        chk("tp pre rst acc", accumulator, 8'd30);
        step("rst add", 0, 24, 6, 1, 1'b1);
        chk("tp rst acc", accumulator, 8'h00);
        step("post rst", 0, 1, 2, 0, 1'b0);
        chk("tp post rst acc", accumulator, 8'd3);

        for (int i = 0; i < 400; i++) begin
            step("rand", int'($urandom_range(7, 0)), int'($urandom_range(255, 0)),
                 int'($urandom_range(255, 0)), int'($urandom_range(3, 0)),
                 ($urandom_range(15, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
